f1_issue_unit: RTL

Sequential front end that drives the combinational F1 function unit. It accepts tagged operation requests on a valid/ready handshake and registers the function code and operands onto the F1 input bus. One cycle later it captures the F1 result into an in-order response FIFO, which drains through a second valid/ready handshake. It sits between the FPU dispatch logic and an F1 instance and is the block that drives F1's input side.

---
 rtl/f1_issue_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/f1_issue_unit.sv
// Issue front end for the combinational F1 unit: registers requests onto the F1
// input bus, captures the result one cycle later and returns it through an in-order FIFO.
module f1_issue_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_f,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_c,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       fu_f,
  output logic [WIDTH-1:0] fu_in0,
  output logic [WIDTH-1:0] fu_in1,
  output logic [WIDTH-1:0] fu_in2,
  input  logic [WIDTH-1:0] fu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      ops_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Valid/ready: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends combinationally on the same-side valid.

  // S1 / F1 input bus registers
  logic [3:0]       fu_f_q,   fu_f_d;
  logic [WIDTH-1:0] fu_in0_q, fu_in0_d;
  logic [WIDTH-1:0] fu_in1_q, fu_in1_d;
  logic [WIDTH-1:0] fu_in2_q, fu_in2_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_valid_q, s1_valid_d;

  // Response FIFO state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [15:0]      ops_done_q, ops_done_d;
  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [WIDTH-1:0] data_mem_d [DEPTH];
  logic [TAG_W-1:0] tag_mem_q  [DEPTH];
  logic [TAG_W-1:0] tag_mem_d  [DEPTH];

  logic req_accept;
  logic push;
  logic pop;
  logic [CNT_W:0] committed;

  // Slots already owed to the FIFO: stored entries plus the one in S1.
  // Built only from flops so the request side never sees rsp_ready.
  assign committed = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q};
  assign req_ready = committed < (CNT_W + 1)'(DEPTH);

  assign req_accept = req_valid && req_ready;
  assign push       = s1_valid_q;
  assign rsp_valid  = (count_q != '0);
  assign pop        = rsp_valid && rsp_ready;

  assign fu_f     = fu_f_q;
  assign fu_in0   = fu_in0_q;
  assign fu_in1   = fu_in1_q;
  assign fu_in2   = fu_in2_q;
  assign rsp_data = data_mem_q[rd_ptr_q];
  assign rsp_tag  = tag_mem_q[rd_ptr_q];
  assign ops_done = ops_done_q;

  // Stage S1: bus holds its last value when idle to avoid toggling F1.
  always_comb begin
    fu_f_d     = fu_f_q;
    fu_in0_d   = fu_in0_q;
    fu_in1_d   = fu_in1_q;
    fu_in2_d   = fu_in2_q;
    s1_tag_d   = s1_tag_q;
    s1_valid_d = 1'b0;
    if (req_accept) begin
      fu_f_d     = req_f;
      fu_in0_d   = req_a;
      fu_in1_d   = req_b;
      fu_in2_d   = req_c;
      s1_tag_d   = req_tag;
      s1_valid_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ops_done_d = ops_done_q;
    data_mem_d = data_mem_q;
    tag_mem_d  = tag_mem_q;
    if (push) begin
      data_mem_d[wr_ptr_q] = fu_out;
      tag_mem_d[wr_ptr_q]  = s1_tag_q;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      ops_done_d = ops_done_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_f_q     <= '0;
      fu_in0_q   <= '0;
      fu_in1_q   <= '0;
      fu_in2_q   <= '0;
      s1_tag_q   <= '0;
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ops_done_q <= '0;
    end else begin
      fu_f_q     <= fu_f_d;
      fu_in0_q   <= fu_in0_d;
      fu_in1_q   <= fu_in1_d;
      fu_in2_q   <= fu_in2_d;
      s1_tag_q   <= s1_tag_d;
      s1_valid_q <= s1_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ops_done_q <= ops_done_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    data_mem_q <= data_mem_d;
    tag_mem_q  <= tag_mem_d;
  end

endmodule
